player_move_ctrl: RTL
=====================

Name: player_move_ctrl

Overview:
- Movement sequencer for the player rectangle object.
- Synchronizes and debounces the four direction buttons, divides the system clock into a game tick, and checks the screen boundary plus external collision/block flags.
- Drives the player object's one-hot direction enables and a single-cycle step pulse, which replaces the free-running button clock.
- Supports press-to-step and hold-to-auto-repeat.

Parameters:
- TICK_DIV, 1000000: system clocks per game tick.
- DEBOUNCE_TICKS, 3: consecutive ticks a button must read high to count as pressed.
- REPEAT_TICKS, 8: ticks spent in HOLD before an auto-repeat step.
- STEP, 12: pixels moved per step; equals the player rectangle size.
- OBJ_SIZE, 12: player width and height.
- H_MAX, 640: screen width.
- V_MAX, 480: screen height.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- btns  input  4  raw buttons, asynchronous: [0] up, [1] down, [2] left, [3] right.
- hPos  input  12  current player left edge.
- vPos  input  12  current player top edge.
- blocked  input  4  external collision flags, same bit order as btns; 1 = move forbidden.
- upEnable  output  1  up direction enable.
- downEnable  output  1  down direction enable.
- leftEnable  output  1  left direction enable.
- rightEnable  output  1  right direction enable.
- stepPulse  output  1  one-clock move strobe.
- moving  output  1  high in STEP/HOLD.
- status  output  2  00 idle, 01 moving, 10 blocked.

Behaviour:
- Reset (rst=0, async): state IDLE; all counters, synchronizers and debounce state cleared; all enables, stepPulse and moving = 0; status = 00. Applies immediately, including mid-STEP or mid-HOLD; no pulse is emitted after reset asserts.
- Tick: counter runs 0..TICK_DIV-1. tick = 1 for exactly one clk cycle when the counter wraps.
- Input sync: 2-flop synchronizer on each btns bit.
- Debounce, per bit, evaluated on tick:
  - synced input high: count increments, saturating at DEBOUNCE_TICKS; pressed = (count == DEBOUNCE_TICKS).
  - synced input low: count = 0 and pressed = 0 on that tick.
- Direction select: priority up > down > left > right among pressed bits. Simultaneous presses resolve by this priority only.
- Boundary check uses 13-bit unsigned arithmetic (no wrap):
  - up allowed if vPos >= STEP.
  - down allowed if vPos + OBJ_SIZE + STEP <= V_MAX.
  - left allowed if hPos >= STEP.
  - right allowed if hPos + OBJ_SIZE + STEP <= H_MAX.
  - Move permitted = allowed AND NOT blocked[dir].
- FSM:
  - IDLE: on tick with any pressed bit -> CHECK.
  - CHECK (1 cycle): latch selected dir. Permitted -> STEP, else -> BLOCKED.
  - STEP (1 cycle): assert the latched dir enable -> HOLD.
  - HOLD:
    - enable stays asserted; stepPulse = 1 in the first HOLD cycle only, so the enable leads the strobe by one clk.
    - On tick: latched dir not pressed -> IDLE; else repeat count increments, and on reaching REPEAT_TICKS -> CHECK with repeat count cleared.
  - BLOCKED: status = 10, enables 0. On tick, if latched dir is no longer pressed -> IDLE; otherwise remain.
- Enables are one-hot or zero, registered, and deasserted in IDLE, CHECK and BLOCKED.
- A higher-priority button pressed during HOLD is taken only at the next CHECK, whether that comes from auto-repeat or from release then IDLE.
- Steps per press: exactly one, plus one per REPEAT_TICKS ticks while held. Maximum one stepPulse per CHECK.
- blocked and position are sampled only in CHECK; changes at other times are ignored.

Test Plan:
- Bench parameters for all scenarios: TICK_DIV=4, DEBOUNCE_TICKS=2, REPEAT_TICKS=3.
- Reset: hold rst=0, btns=4'hF -> all outputs 0, status 00. Release rst, btns=0 for 20 clks -> no stepPulse.
- Single press: hPos=300, vPos=300, btns[3]=1 for 3 ticks, then 0 -> rightEnable high from STEP. Exactly one stepPulse, occurring one clk after rightEnable rises. status returns to 00.
- Auto-repeat: hold btns[0] with vPos=300 for 12 ticks -> stepPulse count = 1 + floor of elapsed HOLD ticks / 3. upEnable is the only enable ever high.
- Boundary:
  - vPos=11, btns[0] held -> BLOCKED, status 10, no stepPulse.
  - hPos=616, btns[3] -> step permitted (616+12+12=640).
  - hPos=617, btns[3] -> blocked.
- Collision and priority:
  - btns=4'b1001, blocked=4'b0001 -> up selected, BLOCKED, no step; right is not taken while up is held.
  - Release up with right still held -> right steps once.
- Reset mid-HOLD: assert rst during HOLD -> enables and moving drop asynchronously; no stepPulse for 10 clks after release with btns=0.

Source files
------------

// File: rtl/player_move_ctrl.sv
// Movement sequencer for the player object: debounced buttons, game tick, boundary and
// collision checks, and a one-hot direction enable followed by a single-cycle step strobe.
module player_move_ctrl #(
  parameter int unsigned TICK_DIV       = 1000000,
  parameter int unsigned DEBOUNCE_TICKS = 3,
  parameter int unsigned REPEAT_TICKS   = 8,
  parameter int unsigned STEP           = 12,
  parameter int unsigned OBJ_SIZE       = 12,
  parameter int unsigned H_MAX          = 640,
  parameter int unsigned V_MAX          = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  btns,
  input  logic [11:0] hPos,
  input  logic [11:0] vPos,
  input  logic [3:0]  blocked,
  output logic        upEnable,
  output logic        downEnable,
  output logic        leftEnable,
  output logic        rightEnable,
  output logic        stepPulse,
  output logic        moving,
  output logic [1:0]  status
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DbW   = $clog2(DEBOUNCE_TICKS + 1);
  localparam int unsigned RepW  = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;

  typedef enum logic [2:0] {StIdle, StCheck, StStep, StHold, StBlocked} state_e;

  state_e            stateQ, stateD;
  logic [TickW-1:0]  tickCntQ;
  logic              tick;
  logic [3:0]        syncQ1, syncQ2;
  logic [DbW-1:0]    dbCntQ [4];
  logic [3:0]        pressed;
  logic              anyPressed;
  logic [1:0]        dirSel, dirQ, dirD;
  logic [RepW-1:0]   repCntQ, repCntD;
  logic [12:0]       h13, v13;
  logic [3:0]        allowed;
  logic              permitted;
  logic [3:0]        enableQ, enableD;
  logic              stepPulseQ, stepPulseD;

  // Game tick
  assign tick = (tickCntQ == TickW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tickCntQ <= '0;
    end else begin
      tickCntQ <= tick ? '0 : tickCntQ + TickW'(1);
    end
  end

  // Button synchronizer and per-bit saturating debounce
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      syncQ1 <= '0;
      syncQ2 <= '0;
    end else begin
      syncQ1 <= btns;
      syncQ2 <= syncQ1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) dbCntQ[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < 4; i++) begin
        if (!syncQ2[i]) begin
          dbCntQ[i] <= '0;
        end else if (dbCntQ[i] != DbW'(DEBOUNCE_TICKS)) begin
          dbCntQ[i] <= dbCntQ[i] + DbW'(1);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) pressed[i] = (dbCntQ[i] == DbW'(DEBOUNCE_TICKS));
    anyPressed = |pressed;
    if (pressed[0])      dirSel = 2'd0;
    else if (pressed[1]) dirSel = 2'd1;
    else if (pressed[2]) dirSel = 2'd2;
    else                 dirSel = 2'd3;
  end

  // Boundary check in 13 bits so hPos/vPos near 4095 cannot wrap into range
  always_comb begin
    h13        = {1'b0, hPos};
    v13        = {1'b0, vPos};
    allowed[0] = v13 >= 13'(STEP);
    allowed[1] = (v13 + 13'(OBJ_SIZE + STEP)) <= 13'(V_MAX);
    allowed[2] = h13 >= 13'(STEP);
    allowed[3] = (h13 + 13'(OBJ_SIZE + STEP)) <= 13'(H_MAX);
    permitted  = allowed[dirSel] & ~blocked[dirSel];
  end

  always_comb begin
    stateD  = stateQ;
    dirD    = dirQ;
    repCntD = repCntQ;
    case (stateQ)
      StIdle: begin
        if (tick && anyPressed) stateD = StCheck;
      end
      StCheck: begin
        // A release landing on the tick that entered CHECK leaves nothing to act on
        if (!anyPressed) begin
          stateD = StIdle;
        end else begin
          dirD   = dirSel;
          stateD = permitted ? StStep : StBlocked;
        end
      end
      StStep: begin
        stateD = StHold;
      end
      StHold: begin
        if (tick) begin
          if (!pressed[dirQ]) begin
            stateD = StIdle;
          end else if (repCntQ == RepW'(REPEAT_TICKS - 1)) begin
            stateD = StCheck;
          end else begin
            repCntD = repCntQ + RepW'(1);
          end
        end
      end
      StBlocked: begin
        if (tick && !pressed[dirQ]) stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
    if (stateD != StHold) repCntD = '0;

    enableD    = (stateD == StStep || stateD == StHold) ? (4'b0001 << dirD) : 4'b0000;
    stepPulseD = (stateQ == StStep);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ     <= StIdle;
      dirQ       <= 2'd0;
      repCntQ    <= '0;
      enableQ    <= 4'b0000;
      stepPulseQ <= 1'b0;
    end else begin
      stateQ     <= stateD;
      dirQ       <= dirD;
      repCntQ    <= repCntD;
      enableQ    <= enableD;
      stepPulseQ <= stepPulseD;
    end
  end

  always_comb begin
    upEnable    = enableQ[0];
    downEnable  = enableQ[1];
    leftEnable  = enableQ[2];
    rightEnable = enableQ[3];
    stepPulse   = stepPulseQ;
    moving      = (stateQ == StStep) || (stateQ == StHold);
    if (stateQ == StBlocked) status = 2'b10;
    else if (moving)         status = 2'b01;
    else                     status = 2'b00;
  end

endmodule
